// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 size codes, FSM
// state codes, width constants and size/alignment helpers.
package data_mem_responder_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Unused funct3 codes behave as full-word accesses.
    function automatic logic [2:0] norm_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: norm_size = f3;
            default:                        norm_size = F3_W;
        endcase
    endfunction

    // Expects a size already passed through norm_size.
    function automatic logic misaligned(input logic [2:0] f3n, input logic [1:0] a);
        case (f3n)
            F3_H, F3_HU: misaligned = a[0];
            F3_W:        misaligned = (a != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_unit.sv
// Combinational byte-lane logic: merges store data into the addressed word
// and extracts/extends load data. Misaligned halfword/word accesses use the
// aligned lanes because only lane[1] (halfword) or nothing (word) is used.
module dmem_lane_unit
    import data_mem_responder_pkg::*;
(
    input  logic [WORD_W-1:0] old_word_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [1:0]        lane_i,
    input  logic [2:0]        size_i,
    output logic [WORD_W-1:0] merged_o,
    output logic [WORD_W-1:0] load_o
);

    logic [2:0]        size_n;
    logic [BYTE_W-1:0] byte_sel;
    logic [15:0]       half_sel;

    assign size_n   = norm_size(size_i);
    assign byte_sel = old_word_i[{lane_i, 3'b000} +: BYTE_W];
    assign half_sel = old_word_i[{lane_i[1], 4'b0000} +: 16];

    // Read-modify-write merge of store data into the current word.
    always_comb begin
        merged_o = old_word_i;
        case (size_n)
            F3_B, F3_BU: merged_o[{lane_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
            F3_H, F3_HU: merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default:     merged_o = wdata_i;
        endcase
    end

    // Lane select and sign/zero extension of load data.
    always_comb begin
        case (size_n)
            F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_o = {24'h0, byte_sel};
            F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_o = {16'h0, half_sel};
            default: load_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// RAM-side responder for the memory-stage data port. Accepts a load/store in
// IDLE, waits LATENCY cycles in ACCESS, completes with a one-cycle mem_ready
// in RESP. Optional request checking is enabled with DMEM_ERR_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for mem_write_enable / mem_read_enable
// ACCESS | request latched, latency counter running; op performed at count 0
// RESP   | mem_ready (and mem_err) asserted for this single cycle
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_write_data,
    input  logic              mem_write_enable,
    input  logic              mem_read_enable,
    input  logic [2:0]        mem_size,
    output logic [31:0]       mem_read_data,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [1:0]            lane_q, lane_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic [2:0]            size_q, size_d;
    logic                  store_q, store_d;
    logic                  bad_q, bad_d;
    logic [WORD_W-1:0]     rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;

    logic [WORD_W-1:0]     mem_q [DEPTH];

    logic [32:0]           diff;
    logic [31:0]           offset;
    logic                  req_bad;
    logic                  do_op;
    logic [WORD_W-1:0]     word_rd, word_wr, load_val;

    // 33-bit subtract so the borrow flags addresses below BASE_ADDR.
    assign diff   = {1'b0, mem_addr} - {1'b0, BASE_ADDR};
    assign offset = diff[31:0];

`ifdef DMEM_ERR_CHECK_EN
    assign req_bad = diff[32]
                   | (|(offset >> (ADDR_WIDTH + 2)))
                   | misaligned(norm_size(mem_size), offset[1:0]);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{diff[32], offset[31:ADDR_WIDTH+2]};
    assign req_bad = 1'b0;
`endif

    assign do_op   = (state_q == ST_ACCESS) && (cnt_q == '0);
    assign word_rd = mem_q[idx_q];

    dmem_lane_unit u_lane (
        .old_word_i (word_rd),
        .wdata_i    (wdata_q),
        .lane_i     (lane_q),
        .size_i     (size_q),
        .merged_o   (word_wr),
        .load_o     (load_val)
    );

    // Next-state, request latching and response generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        store_d = store_q;
        bad_d   = bad_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_write_enable || mem_read_enable) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    idx_d   = offset[ADDR_WIDTH+1:2];
                    lane_d  = offset[1:0];
                    wdata_d = mem_write_data;
                    size_d  = mem_size;
                    store_d = mem_write_enable;
                    bad_d   = req_bad;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    err_d   = bad_q;
                    if (!store_q) begin
                        rdata_d = bad_q ? '0 : load_val;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            store_q <= 1'b0;
            bad_q   <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            store_q <= store_d;
            bad_q   <= bad_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Storage array is not reset; writes only on a clean store completion.
    always_ff @(posedge clk) begin
        if (do_op && store_q && !bad_q) begin
            mem_q[idx_q] <= word_wr;
        end
    end

    assign mem_read_data = rdata_q;
    assign mem_ready     = ready_q;
    assign mem_busy      = (state_q == ST_ACCESS);
    assign mem_err       = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=1 instance for data-path
// checks and one LATENCY=4 instance for busy/ignore timing. Latency is
// reported counting the request cycle as cycle 1.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  size = 3'b010;
    logic        we1 = 1'b0, re1 = 1'b0, we4 = 1'b0, re4 = 1'b0;
    logic [31:0] rdata1, rdata4;
    logic        rdy1, rdy4, busy1, busy4, err1, err4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut1 (
        .clk(clk), .rst(rst), .mem_addr(addr), .mem_write_data(wdata),
        .mem_write_enable(we1), .mem_read_enable(re1), .mem_size(size),
        .mem_read_data(rdata1), .mem_ready(rdy1), .mem_busy(busy1), .mem_err(err1)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4), .BASE_ADDR(32'h0)) u_dut4 (
        .clk(clk), .rst(rst), .mem_addr(addr), .mem_write_data(wdata),
        .mem_write_enable(we4), .mem_read_enable(re4), .mem_size(size),
        .mem_read_data(rdata4), .mem_ready(rdy4), .mem_busy(busy4), .mem_err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on the selected instance; waits (bounded) for mem_ready.
    task automatic do_req(input bit sel, input logic we, input logic re,
                          input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        addr = a; wdata = d; size = sz;
        if (sel) begin we4 = we; re4 = re; end
        else     begin we1 = we; re1 = re; end
        @(posedge clk);
        @(negedge clk);
        we1 = 1'b0; re1 = 1'b0; we4 = 1'b0; re4 = 1'b0;
        n = 0;
        while (!(sel ? rdy4 : rdy1) && n < 24) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        lat = (sel ? rdy4 : rdy1) ? n + 2 : -1;
        rd  = sel ? rdata4 : rdata1;
        er  = sel ? err4 : err1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses;
    int          at_cycle;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {31'b0, rdy1}, 32'd0);
        chk("reset_busy", {31'b0, busy1}, 32'd0);
        chk("reset_rdata", rdata1, 32'h0);
        chk("reset_err", {31'b0, err1}, 32'd0);
        chk("reset_ready4", {31'b0, rdy4}, 32'd0);
        rst = 1'b1;

        // SW then LW, LATENCY=1
        do_req(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat);
        chk("sw_latency", lat, 32'd3);
        chk("sw_err", {31'b0, er}, 32'd0);
        @(negedge clk);
        chk("ready_one_cycle", {31'b0, rdy1}, 32'd0);
        do_req(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 3'b010, rd, er, lat);
        chk("lw_10", rd, 32'hDEADBEEF);
        chk("lw_latency", lat, 32'd3);

        // Byte store and byte loads
        do_req(1'b0, 1'b1, 1'b0, 32'h11, 32'h0000007F, 3'b000, rd, er, lat);
        do_req(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 3'b010, rd, er, lat);
        chk("lw_after_sb", rd, 32'hDEAD7FEF);
        do_req(1'b0, 1'b0, 1'b1, 32'h13, 32'h0, 3'b000, rd, er, lat);
        chk("lb_13", rd, 32'hFFFFFFDE);
        do_req(1'b0, 1'b0, 1'b1, 32'h13, 32'h0, 3'b100, rd, er, lat);
        chk("lbu_13", rd, 32'h000000DE);
        do_req(1'b0, 1'b0, 1'b1, 32'h11, 32'h0, 3'b000, rd, er, lat);
        chk("lb_11_pos", rd, 32'h0000007F);

        // Halfword store and halfword loads
        do_req(1'b0, 1'b1, 1'b0, 32'h12, 32'h00008001, 3'b001, rd, er, lat);
        do_req(1'b0, 1'b0, 1'b1, 32'h12, 32'h0, 3'b001, rd, er, lat);
        chk("lh_12", rd, 32'hFFFF8001);
        do_req(1'b0, 1'b0, 1'b1, 32'h12, 32'h0, 3'b101, rd, er, lat);
        chk("lhu_12", rd, 32'h00008001);
        do_req(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 3'b001, rd, er, lat);
        chk("lh_10", rd, 32'h00007FEF);
        do_req(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 3'b011, rd, er, lat);
        chk("lw_illegal_size", rd, 32'h80017FEF);

        // we and re together: store wins, load data held
        do_req(1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678, 3'b010, rd, er, lat);
        chk("wr_rd_data_held", rd, 32'h80017FEF);
        do_req(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 3'b010, rd, er, lat);
        chk("lw_20", rd, 32'h12345678);

        // Misaligned halfword load
        do_req(1'b0, 1'b0, 1'b1, 32'h13, 32'h0, 3'b001, rd, er, lat);
`ifdef DMEM_ERR_CHECK_EN
        chk("lh_13_misaligned", rd, 32'h0);
        chk("lh_13_err", {31'b0, er}, 32'd1);
`else
        chk("lh_13_misaligned", rd, 32'hFFFF8001);
        chk("lh_13_err", {31'b0, er}, 32'd0);
`endif

        // LATENCY=4: second request during ACCESS is ignored
        @(negedge clk);
        addr = 32'h40; wdata = 32'hAAAA5555; size = 3'b010; we4 = 1'b1;
        @(posedge clk);
        pulses = 0;
        at_cycle = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                wdata = 32'h0BAD0BAD;
                chk("busy4_in_access", {31'b0, busy4}, 32'd1);
            end
            if (i == 1) we4 = 1'b0;
            if (rdy4) begin
                pulses++;
                at_cycle = i + 2;
            end
            if (i != 0) @(posedge clk);
            else @(posedge clk);
        end
        chk("lat4_pulse_count", pulses, 32'd1);
        chk("lat4_pulse_cycle", at_cycle, 32'd6);
        do_req(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 3'b010, rd, er, lat);
        chk("lat4_lw_40", rd, 32'hAAAA5555);
        chk("lat4_lw_latency", lat, 32'd6);

        // Reset in the middle of an access
        do_req(1'b0, 1'b1, 1'b0, 32'h30, 32'hCAFEF00D, 3'b010, rd, er, lat);
        @(negedge clk);
        addr = 32'h30; wdata = 32'h11111111; size = 3'b010; we1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        we1 = 1'b0;
        chk("busy_before_rst", {31'b0, busy1}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy1}, 32'd0);
        chk("rst_ready", {31'b0, rdy1}, 32'd0);
        chk("rst_rdata", rdata1, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rdy1) pulses++;
        end
        chk("rst_no_ready", pulses, 32'd0);
        do_req(1'b0, 1'b0, 1'b1, 32'h30, 32'h0, 3'b010, rd, er, lat);
        chk("lw_30_after_rst", rd, 32'hCAFEF00D);
        do_req(1'b0, 1'b0, 1'b1, 32'h31, 32'h0, 3'b010, rd, er, lat);
`ifdef DMEM_ERR_CHECK_EN
        chk("lw_31_data", rd, 32'h0);
        chk("lw_31_err", {31'b0, er}, 32'd1);
`else
        chk("lw_31_data", rd, 32'hCAFEF00D);
        chk("lw_31_err", {31'b0, er}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
